regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined MIPS datapath. It provides NREAD registered read ports, two write ports with fixed priority, optional write-to-read bypass, and a hardwired zero register. A per-register pending-write scoreboard lets the hazard unit stall on registers whose writeback is still outstanding. It sits between decode (reads, issue) and writeback (writes).

---
 rtl/mips_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_mp.sv | 144 ++++++++++++++
 tb/tb_regfile_mp.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: default operand widths and
// the architectural zero register index.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

endpackage : mips_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard. A register becomes busy when an
// instruction producing it issues and is released when its writeback lands.
// If issue and writeback hit the same register in one cycle, the new
// producer is outstanding, so the set wins.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        waddr0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [(1<<ADDR_W)-1:0]   busy_q_o,
    output logic [(1<<ADDR_W)-1:0]   busy_d_o,
    output logic                     any_busy_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: writes clear, then issue sets, zero register pinned low.
    always_comb begin
        busy_d = busy_q;
        if (we0_i) begin
            busy_d[waddr0_i] = 1'b0;
        end
        if (we1_i) begin
            busy_d[waddr1_i] = 1'b0;
        end
        if (iss_en_i) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[REG_ZERO] = 1'b0;
        end
    end

    // Busy-bit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_q_o   = busy_q;
    assign busy_d_o   = busy_d;
    assign any_busy_o = |busy_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD registered read ports, two prioritised
// write ports, optional write-to-read bypass, hardwired zero register and a
// pending-write scoreboard for the hazard unit.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int unsigned           DATA_W   = DATA_W_DEF,
    parameter int unsigned           ADDR_W   = ADDR_W_DEF,
    parameter int unsigned           NREAD    = 2,
    parameter int unsigned           ZERO_REG = 1,
    parameter int unsigned           BYPASS   = 1,
    parameter int unsigned           INIT_IDX = 0,
    parameter logic [DATA_W-1:0]     INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREAD-1:0]          rd_en,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         waddr0,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         waddr1,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic                      iss_en,
    input  logic [ADDR_W-1:0]         iss_addr,
    output logic                      any_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] mem_d   [DEPTH];
    logic [DATA_W-1:0] rdata_q [NREAD];
    logic [DATA_W-1:0] rdata_d [NREAD];
    logic [NREAD-1:0]  rbusy_q;
    logic [NREAD-1:0]  rbusy_d;
    logic [ADDR_W-1:0] ra      [NREAD];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr0;
    logic              wr1;
    logic              iss_ok;

    // Qualify writes and issue against the hardwired zero register.
    always_comb begin
        wr0    = we0;
        wr1    = we1;
        iss_ok = iss_en;
        if (ZERO_REG != 0) begin
            wr0    = we0 && (waddr0 != ZADDR);
            wr1    = we1 && (waddr1 != ZADDR);
            iss_ok = iss_en && (iss_addr != ZADDR);
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .we0_i      (we0),
        .waddr0_i   (waddr0),
        .we1_i      (we1),
        .waddr1_i   (waddr1),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_q_o   (busy_q),
        .busy_d_o   (busy_d),
        .any_busy_o (any_busy)
    );

    // Post-write storage image: port 1 applied last so it wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (wr0) begin
            mem_d[waddr0] = wdata0;
        end
        if (wr1) begin
            mem_d[waddr1] = wdata1;
        end
    end

    // Storage registers with optional single-register preset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= ((INIT_IDX != 0) && (k == INIT_IDX)) ? INIT_VAL : '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read capture. Bypass reads the post-write image, which already encodes
    // port-1-over-port-0 forwarding; the same holds for the busy bits.
    always_comb begin
        rdata_d = rdata_q;
        rbusy_d = rbusy_q;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra[i] = raddr[i*ADDR_W +: ADDR_W];
            if (rd_en[i]) begin
                if ((ZERO_REG != 0) && (ra[i] == ZADDR)) begin
                    rdata_d[i] = '0;
                    rbusy_d[i] = 1'b0;
                end else if (BYPASS != 0) begin
                    rdata_d[i] = mem_d[ra[i]];
                    rbusy_d[i] = busy_d[ra[i]];
                end else begin
                    rdata_d[i] = mem_q[ra[i]];
                    rbusy_d[i] = busy_q[ra[i]] | (iss_ok && (iss_addr == ra[i]));
                end
            end
        end
    end

    // Registered read data and busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREAD; i++) begin
                rdata_q[i] <= '0;
            end
            rbusy_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
        end
    end

    // Pack read ports onto the flat output bus.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            rdata[i*DATA_W +: DATA_W] = rdata_q[i];
        end
    end

    assign rbusy = rbusy_q;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a non-bypassing instance
// share one stimulus stream; an array-level reference model predicts both.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int PIDX  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  raddr;
    logic              we0, we1, iss_en;
    logic [AW-1:0]     waddr0, waddr1, iss_addr;
    logic [DW-1:0]     wdata0, wdata1;

    logic [NR*DW-1:0]  rdata_b, rdata_n;
    logic [NR-1:0]     rbusy_b, rbusy_n;
    logic              any_b, any_n;

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .BYPASS(1),
        .INIT_IDX(PIDX), .INIT_VAL(32'd10)
    ) dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .raddr(raddr),
        .rdata(rdata_b), .rbusy(rbusy_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_b)
    );

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .BYPASS(0),
        .INIT_IDX(PIDX), .INIT_VAL(32'd10)
    ) dut_nob (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .raddr(raddr),
        .rdata(rdata_n), .rbusy(rbusy_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_n)
    );

    // Reference model state
    typedef struct {
        logic [NR*DW-1:0] rd_b;
        logic [NR*DW-1:0] rd_n;
        logic [NR-1:0]    rb_b;
        logic [NR-1:0]    rb_n;
        logic             ab;
    } exp_t;

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    exp_t          cur;
    exp_t          q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 0;
        end
        m_mem[PIDX] = 32'd10;
        cur.rd_b = '0; cur.rd_n = '0; cur.rb_b = '0; cur.rb_n = '0; cur.ab = 1'b0;
    endtask

    // One rising edge in spec terms: capture pre-state, commit writes in
    // priority order, issue after writes, then derive the read results.
    task automatic model_edge();
        logic [DW-1:0] old_mem  [DEPTH];
        bit            old_busy [DEPTH];
        int            a;
        bit            any;
        for (int k = 0; k < DEPTH; k++) begin
            old_mem[k]  = m_mem[k];
            old_busy[k] = m_busy[k];
        end
        if (we0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 0; end
        if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 0; end
        if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
        for (int i = 0; i < NR; i++) begin
            if (rd_en[i]) begin
                a = int'(raddr[i*AW +: AW]);
                if (a == 0) begin
                    cur.rd_b[i*DW +: DW] = '0; cur.rb_b[i] = 1'b0;
                    cur.rd_n[i*DW +: DW] = '0; cur.rb_n[i] = 1'b0;
                end else begin
                    cur.rd_b[i*DW +: DW] = m_mem[a];
                    cur.rb_b[i]          = m_busy[a];
                    cur.rd_n[i*DW +: DW] = old_mem[a];
                    cur.rb_n[i]          = old_busy[a] || (iss_en && int'(iss_addr) == a);
                end
            end
        end
        any = 0;
        for (int k = 0; k < DEPTH; k++) any = any || m_busy[k];
        cur.ab = any;
    endtask

    task automatic set_idle();
        rd_en = '0; raddr = '0;
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        iss_en = 0; iss_addr = '0;
    endtask

    task automatic set_read(input int p0, input int p1);
        rd_en = 2'b11;
        raddr = {AW'(p1), AW'(p0)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge();
        q.push_back(cur);
    endtask

    // Let an edge go by, then pull reset asynchronously well before sampling.
    task automatic reset_mid();
        @(posedge clk);
        #1;
        model_edge();
        #1;
        rst_n = 1'b0;
        model_reset();
        q.push_back(cur);
        set_idle();
    endtask

    // Monitor: one expected response per clock, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rdata_bypass",    rdata_b,         e.rd_b);
            chk("rbusy_bypass",    {62'b0, rbusy_b}, {62'b0, e.rb_b});
            chk("any_busy_bypass", {63'b0, any_b},   {63'b0, e.ab});
            chk("rdata_nobyp",     rdata_n,         e.rd_n);
            chk("rbusy_nobyp",     {62'b0, rbusy_n}, {62'b0, e.rb_n});
            chk("any_busy_nobyp",  {63'b0, any_n},   {63'b0, e.ab});
        end
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();

        // Reset, then read the preset register and a plain one
        step(); step();
        rst_n = 1'b1;
        set_read(10, 3);
        step();

        // Same-address write collision, then zero-register write
        set_idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'h11;
        we1 = 1; waddr1 = 5; wdata1 = 32'h22;
        step();
        set_idle(); set_read(5, 0);
        step();
        set_idle(); we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF;
        step();
        set_idle(); set_read(0, 5);
        step();

        // Write and read r7 in the same cycle
        set_idle(); set_read(7, 7);
        we0 = 1; waddr0 = 7; wdata0 = 32'hABCD;
        step();

        // Scoreboard set, clear, and set-wins collision
        set_idle(); iss_en = 1; iss_addr = 8;
        step();
        set_idle(); set_read(8, 0);
        step();
        set_idle(); set_read(8, 5); we1 = 1; waddr1 = 8; wdata1 = 32'd5;
        step();
        set_idle(); set_read(8, 5);
        step();
        set_idle(); set_read(8, 0);
        iss_en = 1; iss_addr = 8; we0 = 1; waddr0 = 8; wdata0 = 32'd9;
        step();
        set_idle(); set_read(8, 5);
        step();

        // Hold: reads disabled while the addressed registers change
        for (int c = 0; c < 3; c++) begin
            set_idle();
            we0 = 1; waddr0 = 8; wdata0 = 32'h100 + c;
            we1 = 1; waddr1 = 5; wdata1 = 32'h200 + c;
            iss_en = 1; iss_addr = 5;
            step();
        end

        // Asynchronous reset with r4 busy and writes in flight
        set_idle(); iss_en = 1; iss_addr = 4;
        step();
        set_idle(); we0 = 1; waddr0 = 4; wdata0 = 32'h44; iss_en = 1; iss_addr = 6;
        reset_mid();
        step();
        rst_n = 1'b1;
        set_read(4, 6);
        step();

        // Randomised traffic over a narrow address window for collisions
        for (int c = 0; c < 400; c++) begin
            set_idle();
            rd_en    = NR'($urandom);
            raddr    = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            we0      = ($urandom_range(0, 2) != 0);
            waddr0   = AW'($urandom_range(0, 15));
            wdata0   = $urandom;
            we1      = ($urandom_range(0, 2) == 0);
            waddr1   = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, 15));
            wdata1   = $urandom;
            iss_en   = ($urandom_range(0, 1) == 0);
            iss_addr = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, 15));
            if ($urandom_range(0, 60) == 0) begin
                reset_mid();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        set_idle();
        step();
        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp
